// File: rtl/riscv_data_mem_bridge.sv
// LSU data-port slave onto a 1-cycle-latency single-port SRAM, with programmable grant wait states.
// Optional DMEM_RANGE_CHECK_EN flags and suppresses accesses outside the BASE_ADDR window.
module riscv_data_mem_bridge #(
  parameter int unsigned SRAM_AW     = 14,
  parameter logic [31:0] BASE_ADDR   = 32'h0010_0000,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               data_req_i,
  output logic               data_gnt_o,
  output logic               data_rvalid_o,
  output logic               data_err_o,
  input  logic [31:0]        data_addr_i,
  input  logic               data_we_i,
  input  logic [3:0]         data_be_i,
  input  logic [31:0]        data_wdata_i,
  output logic [31:0]        data_rdata_o,
  output logic               sram_en_o,
  output logic               sram_we_o,
  output logic [3:0]         sram_be_o,
  output logic [SRAM_AW-1:0] sram_addr_o,
  output logic [31:0]        sram_wdata_o,
  input  logic [31:0]        sram_rdata_i
);

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  typedef enum logic {S_IDLE, S_WAIT} state_e;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       rvalid_q, rvalid_d;
  logic       err_q, err_d;
  logic       we_q, we_d;
  logic       gnt, err;

  // Counter holds the number of req cycles seen so far; grant fires when it reaches WS.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (data_req_i) begin
          if (WS == 4'd0) begin
            gnt = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 4'd1;
          end
        end
      end
      S_WAIT: begin
        if (!data_req_i) begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == WS) begin
          gnt     = 1'b1;
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
    endcase
  end

`ifdef DMEM_RANGE_CHECK_EN
  logic in_win;
  assign in_win = (data_addr_i[31:SRAM_AW+2] == BASE_ADDR[31:SRAM_AW+2]);
  assign err    = gnt & ~in_win;
`else
  assign err = 1'b0;
`endif

  // Byte-offset bits are never used; upper bits only matter with the range check.
  logic unused_addr;
  assign unused_addr = ^{data_addr_i[31:SRAM_AW+2], data_addr_i[1:0]};

  always_comb begin
    rvalid_d = gnt;
    err_d    = err;
    we_d     = gnt ? data_we_i : we_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      we_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      we_q     <= we_d;
    end
  end

  assign data_gnt_o    = gnt;
  assign data_err_o    = err;
  assign data_rvalid_o = rvalid_q;
  assign data_rdata_o  = (rvalid_q & ~we_q & ~err_q) ? sram_rdata_i : 32'h0;

  assign sram_en_o    = gnt & ~err;
  assign sram_we_o    = data_we_i;
  assign sram_be_o    = data_be_i;
  assign sram_addr_o  = data_addr_i[SRAM_AW+1:2];
  assign sram_wdata_o = data_wdata_i;

endmodule

// File: tb/tb_riscv_data_mem_bridge.sv
// Scoreboard bench: two bridges (0 and 3 wait states), each on its own SRAM model,
// checked against a word-array reference memory.
module tb_riscv_data_mem_bridge;
  localparam int          AW    = 14;
  localparam int          DEPTH = 1 << AW;
  localparam logic [31:0] BASE  = 32'h0010_0000;

  typedef struct {
    int          inst;
    int          cyc;
    logic [31:0] rdata;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mem_init = 1'b1;
  logic [1:0]         req = '0, we = '0;
  logic [1:0][31:0]   addr = '0, wdata = '0;
  logic [1:0][3:0]    be = '0;
  logic [1:0]         gnt, rvalid, err, sen, swe;
  logic [1:0][31:0]   rdata, swdata, srdata;
  logic [1:0][3:0]    sbe;
  logic [1:0][AW-1:0] saddr;

  logic [31:0] smem [2][DEPTH];
  logic [31:0] rmem [2][DEPTH];
  exp_t exp_q[$];
  int cyc = 0, checks = 0, errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    riscv_data_mem_bridge #(.SRAM_AW(AW), .BASE_ADDR(BASE), .WAIT_STATES(g * 3)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .data_req_i(req[g]), .data_gnt_o(gnt[g]), .data_rvalid_o(rvalid[g]), .data_err_o(err[g]),
      .data_addr_i(addr[g]), .data_we_i(we[g]), .data_be_i(be[g]), .data_wdata_i(wdata[g]),
      .data_rdata_o(rdata[g]),
      .sram_en_o(sen[g]), .sram_we_o(swe[g]), .sram_be_o(sbe[g]), .sram_addr_o(saddr[g]),
      .sram_wdata_o(swdata[g]), .sram_rdata_i(srdata[g]));
  end

  function automatic logic [31:0] seed(int k, int i);
    return (i * 32'h9E37_79B1) ^ (k * 32'h5BD1_E995) ^ 32'h1234_5678;
  endfunction

  // Environment SRAM: synchronous, byte-masked writes, 1-cycle read latency.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int k = 0; k < 2; k++)
        for (int i = 0; i < DEPTH; i++) smem[k][i] <= seed(k, i);
    end else begin
      for (int k = 0; k < 2; k++)
        if (sen[k]) begin
          if (swe[k]) begin
            for (int b = 0; b < 4; b++)
              if (sbe[k][b]) smem[k][saddr[k]][8*b +: 8] <= swdata[k][8*b +: 8];
          end else begin
            srdata[k] <= smem[k][saddr[k]];
          end
        end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  function automatic int ws_of(int k);
    return (k == 0) ? 0 : 3;
  endfunction

  function automatic logic exp_err(logic [31:0] a);
`ifdef DMEM_RANGE_CHECK_EN
    logic [31:0] bv;
    bv = BASE;
    return a[31:AW+2] != bv[31:AW+2];
`else
    return (a == 32'hFFFF_FFFF) && (a != 32'hFFFF_FFFF);
`endif
  endfunction

  // Response monitor: every rvalid must match the oldest expectation, in its exact cycle.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++)
      if (rvalid[k] === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("spurious_rvalid", {31'b0, rvalid[k]}, 32'h0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("rvalid_inst", k, e.inst);
          chk("rvalid_cycle", cyc, e.cyc);
          chk("rdata", rdata[k], e.rdata);
        end
      end
  end

  // One request held until granted; kill asserts reset inside the grant cycle.
  task automatic access(input int k, input logic w, input logic [31:0] a,
                        input logic [3:0] b, input logic [31:0] d, input bit kill);
    int n, pre_en, idx;
    logic e;
    logic [31:0] rd;
    @(posedge clk); #1;
    req[k] = 1'b1; we[k] = w; addr[k] = a; be[k] = b; wdata[k] = d;
    n = 0; pre_en = 0;
    forever begin
      @(negedge clk);
      if (gnt[k]) break;
      if (sen[k]) pre_en++;
      n++;
      if (n > 40) begin
        chk("gnt_timeout", n, ws_of(k));
        req[k] = 1'b0;
        return;
      end
    end
    idx = int'(a[AW+1:2]);
    e = exp_err(a);
    chk("gnt_latency", n, ws_of(k));
    chk("sram_en_before_gnt", pre_en, 0);
    chk("err", {31'b0, err[k]}, {31'b0, e});
    chk("sram_en", {31'b0, sen[k]}, {31'b0, ~e});
    if (!e) begin
      chk("sram_addr", {18'b0, saddr[k]}, idx);
      if (w) begin
        chk("sram_we", {31'b0, swe[k]}, 32'h1);
        chk("sram_be", {28'b0, sbe[k]}, {28'b0, b});
        chk("sram_wdata", swdata[k], d);
      end
    end
    if (kill) begin
      rst_n = 1'b0;
      req[k] = 1'b0;
      return;
    end
    rd = (w || e) ? 32'h0 : rmem[k][idx];
    if (w && !e)
      for (int j = 0; j < 4; j++)
        if (b[j]) rmem[k][idx][8*j +: 8] = d[8*j +: 8];
    exp_q.push_back('{inst: k, cyc: cyc + 1, rdata: rd});
  endtask

  task automatic go_idle(input int k, input int n);
    @(posedge clk); #1;
    req[k] = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  task automatic rand_access(input int k);
    logic [31:0] a, bv;
    logic [3:0] b;
    bv = BASE;
    a = $urandom;
    if ($urandom_range(3) != 0) a[31:AW+2] = bv[31:AW+2];
    b = 4'($urandom_range(15, 1));
    access(k, 1'($urandom_range(1)), a, b, $urandom, 1'b0);
    if ($urandom_range(3) == 0) go_idle(k, $urandom_range(2));
  endtask

  task automatic quiet(input int k, input int n, input string nm);
    repeat (n) begin
      @(negedge clk);
      chk({nm, "_gnt"}, {31'b0, gnt[k]}, 32'h0);
      chk({nm, "_rvalid"}, {31'b0, rvalid[k]}, 32'h0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < DEPTH; i++) rmem[k][i] = seed(k, i);
    @(posedge clk); #1 mem_init = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_gnt", {31'b0, gnt[k]}, 32'h0);
      chk("rst_rvalid", {31'b0, rvalid[k]}, 32'h0);
      chk("rst_err", {31'b0, err[k]}, 32'h0);
      chk("rst_rdata", rdata[k], 32'h0);
      chk("rst_sram_en", {31'b0, sen[k]}, 32'h0);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    quiet(0, 2, "post_rst");

    // zero wait states: directed, back-to-back, out-of-window, random
    access(0, 1'b1, 32'h0010_0008, 4'hF, 32'hDEAD_BEEF, 1'b0);
    access(0, 1'b0, 32'h0010_0008, 4'hF, 32'h0, 1'b0);
    go_idle(0, 1);
    access(0, 1'b1, 32'h0010_0008, 4'b0100, 32'h00AB_0000, 1'b0);
    access(0, 1'b0, 32'h0010_0008, 4'hF, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) access(0, 1'b0, BASE + 32'(4 * i + 16), 4'hF, 32'h0, 1'b0);
    access(0, 1'b0, 32'h0000_0100, 4'hF, 32'h0, 1'b0);
    for (int i = 0; i < 40; i++) rand_access(0);
    go_idle(0, 2);

    // three wait states: directed, aborted request, random
    access(1, 1'b0, 32'h0010_0008, 4'hF, 32'h0, 1'b0);
    go_idle(1, 1);
    @(posedge clk); #1 req[1] = 1'b1; addr[1] = BASE; we[1] = 1'b0;
    quiet(1, 2, "abort");
    go_idle(1, 1);
    access(1, 1'b1, 32'h0010_0040, 4'b1001, 32'hA5C3_3C5A, 1'b0);
    access(1, 1'b0, 32'h0010_0040, 4'hF, 32'h0, 1'b0);
    for (int i = 0; i < 30; i++) rand_access(1);
    go_idle(1, 2);

    // reset while waiting, then reset inside a grant cycle
    @(posedge clk); #1 req[1] = 1'b1; addr[1] = BASE; we[1] = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b0; req[1] = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    quiet(1, 4, "rst_wait");
    access(1, 1'b0, 32'h0010_0020, 4'hF, 32'h0, 1'b1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    quiet(1, 4, "rst_gnt");
    access(1, 1'b0, 32'h0010_0020, 4'hF, 32'h0, 1'b0);
    go_idle(1, 4);

    chk("pending_rsp", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
